// File: rtl/control_step_sequencer_pkg.sv
// Shared opcodes, step states, ALU selects and IR field positions for the
// control step sequencer and its step decoder.
package seq_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b10001;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam int IR_OP_HI = 31;
  localparam int IR_RA_HI = 26;
  localparam int IR_RB_HI = 22;
  localparam int IR_RC_HI = 18;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_e;

  // Instructions that take the three-step Y/Z ALU path.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_ADDI);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_step_sequencer_step_decoder.sv
// Combinational step decoder: state + opcode + register fields -> datapath strobes.
// The IN/OUT port opcodes decode only when SEQ_IO_EN is defined.
module step_decoder
  import seq_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  state_e           state,
  input  logic [OPW-1:0]   op,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic             PCout,
  output logic             MDRout,
  output logic             Zlo_out,
  output logic             Zhi_out,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             Inport_out,
  output logic [NREGS-1:0] r_out,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zin,
  output logic             IncPC,
  output logic             Read,
  output logic             OutPort_in,
  output logic [NREGS-1:0] r_in,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             halted
);

  logic       src_en, dst_en;
  logic [3:0] src_idx, dst_idx;

  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; Zlo_out = 1'b0; Zhi_out = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; Inport_out = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; IncPC = 1'b0; Read = 1'b0; OutPort_in = 1'b0;
    alu_op = ALU_ADD;
    busy = 1'b0; done = 1'b0; illegal = 1'b0; halted = 1'b0;
    src_en = 1'b0; src_idx = 4'd0;
    dst_en = 1'b0; dst_idx = 4'd0;

    case (state)
      S_T0: begin
        busy = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        busy = 1'b1; Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            src_en = 1'b1; src_idx = rb; Yin = 1'b1;
          end
          OP_MFHI: begin
            HIout = 1'b1; dst_en = 1'b1; dst_idx = ra; done = 1'b1;
          end
          OP_MFLO: begin
            LOout = 1'b1; dst_en = 1'b1; dst_idx = ra; done = 1'b1;
          end
          OP_NOP, OP_HALT: done = 1'b1;
`ifdef SEQ_IO_EN
          OP_IN: begin
            Inport_out = 1'b1; dst_en = 1'b1; dst_idx = ra; done = 1'b1;
          end
          OP_OUT: begin
            src_en = 1'b1; src_idx = ra; OutPort_in = 1'b1; done = 1'b1;
          end
`endif
          default: begin
            done = 1'b1; illegal = 1'b1;
          end
        endcase
      end
      S_T4: begin
        busy = 1'b1;
        // Only ALU-class opcodes reach T4; ADDI takes its operand from C.
        if (op == OP_ADDI) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
        end else if (is_alu_op(op)) begin
          src_en = 1'b1; src_idx = rc; Zin = 1'b1; alu_op = alu_sel(op);
        end
      end
      S_T5: begin
        busy = 1'b1; Zlo_out = 1'b1; dst_en = 1'b1; dst_idx = ra; done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range register indices (NREGS < 16) simply match no lane.
  always_comb begin
    r_out = '0;
    r_in  = '0;
    for (int i = 0; i < NREGS; i++) begin
      r_out[i] = src_en && (src_idx == 4'(i));
      r_in[i]  = dst_en && (dst_idx == 4'(i));
    end
  end

endmodule

// File: rtl/control_step_sequencer.sv
// Single-instruction fetch/execute control sequencer feeding the bus source encoder.
// Optional IN/OUT port instructions are enabled by defining SEQ_IO_EN.
module control_step_sequencer
  import seq_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MDRout,
  output logic             Zlo_out,
  output logic             Zhi_out,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             Inport_out,
  output logic [NREGS-1:0] r_out,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zin,
  output logic             IncPC,
  output logic             Read,
  output logic             OutPort_in,
  output logic [NREGS-1:0] r_in,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             halted
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op;
  logic [3:0]     ra, rb, rc;
  logic           unused_ir;

  assign op = ir[IR_OP_HI -: OPW];
  assign ra = ir[IR_RA_HI -: 4];
  assign rb = ir[IR_RB_HI -: 4];
  assign rc = ir[IR_RC_HI -: 4];
  assign unused_ir = ^ir[14:0];

  always_ff @(posedge clock) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_alu_op(op))      state_d = S_T4;
        else if (op == OP_HALT) state_d = S_HALT;
        else                    state_d = S_IDLE;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  step_decoder #(.NREGS(NREGS), .OPW(OPW)) u_dec (
    .state      (state_q),
    .op         (op),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .PCout      (PCout),
    .MDRout     (MDRout),
    .Zlo_out    (Zlo_out),
    .Zhi_out    (Zhi_out),
    .HIout      (HIout),
    .LOout      (LOout),
    .Cout       (Cout),
    .Inport_out (Inport_out),
    .r_out      (r_out),
    .PCin       (PCin),
    .IRin       (IRin),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .IncPC      (IncPC),
    .Read       (Read),
    .OutPort_in (OutPort_in),
    .r_in       (r_in),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .halted     (halted)
  );

endmodule

// File: tb/tb_control_step_sequencer.sv
// Scoreboard bench: per-cycle expected control words are queued when an
// instruction is launched and compared against the DUT on each falling edge.
module tb_control_step_sequencer;

  typedef struct packed {
    logic PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Cout, Inport_out;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read, OutPort_in;
    logic [3:0] alu_op;
    logic busy, done, illegal, halted;
  } ctl_t;

  logic clock = 1'b0, clear = 1'b0, start = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Cout, Inport_out;
  logic [15:0] r_out, r_in;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read, OutPort_in;
  logic [3:0] alu_op;
  logic busy, done, illegal, halted;

  int n_chk = 0, n_err = 0;
  ctl_t exp_q[$];
  ctl_t obs;

  control_step_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MDRout(MDRout), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .Inport_out(Inport_out),
    .r_out(r_out), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .IncPC(IncPC), .Read(Read), .OutPort_in(OutPort_in),
    .r_in(r_in), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal), .halted(halted)
  );

  always #5 clock = ~clock;

  // alu_op is only meaningful while Zin is high.
  assign obs = {PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Cout, Inport_out,
                r_out, r_in, PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read,
                OutPort_in, (Zin ? alu_op : 4'd0), busy, done, illegal, halted};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  function automatic logic is_alu(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100};
  endfunction

  // Expected control word for step s (0..5 = T0..T5, 6 = HALT).
  function automatic ctl_t step_exp(input int s, input logic [31:0] instr);
    ctl_t e = '0;
    logic [4:0] op = instr[31:27];
    logic [3:0] ra = instr[26:23];
    logic [3:0] rb = instr[22:19];
    logic [3:0] rc = instr[18:15];
    case (s)
      0: begin e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; end
      1: begin e.busy = 1; e.Zlo_out = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; end
      2: begin e.busy = 1; e.MDRout = 1; e.IRin = 1; end
      3: begin
        e.busy = 1;
        case (op)
          5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100: begin
            e.r_out[rb] = 1; e.Yin = 1;
          end
          5'b10000: begin e.HIout = 1; e.r_in[ra] = 1; e.done = 1; end
          5'b10001: begin e.LOout = 1; e.r_in[ra] = 1; e.done = 1; end
          5'b11010, 5'b11011: e.done = 1;
`ifdef SEQ_IO_EN
          5'b10110: begin e.Inport_out = 1; e.r_in[ra] = 1; e.done = 1; end
          5'b10111: begin e.r_out[ra] = 1; e.OutPort_in = 1; e.done = 1; end
`endif
          default: begin e.done = 1; e.illegal = 1; end
        endcase
      end
      4: begin
        e.busy = 1; e.Zin = 1;
        if (op == 5'b01100) e.Cout = 1;
        else e.r_out[rc] = 1;
        e.alu_op = (op == 5'b00100) ? 4'd1 : (op == 5'b00101) ? 4'd2 :
                   (op == 5'b00110) ? 4'd3 : 4'd0;
      end
      5: begin e.busy = 1; e.Zlo_out = 1; e.r_in[ra] = 1; e.done = 1; end
      6: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Launch one instruction from IDLE at a falling edge and score every cycle.
  // clr_at pulls clear low during that cycle; extra appends IDLE/HALT cycles.
  task automatic run(input logic [31:0] instr, input int stalls, input int clr_at,
                     input logic hold_start, input int extra);
    logic [4:0] op = instr[31:27];
    int n;
    ctl_t e;
    exp_q.push_back(step_exp(0, instr));
    for (int i = 0; i <= stalls; i++) exp_q.push_back(step_exp(1, instr));
    exp_q.push_back(step_exp(2, instr));
    exp_q.push_back(step_exp(3, instr));
    if (is_alu(op)) begin
      exp_q.push_back(step_exp(4, instr));
      exp_q.push_back(step_exp(5, instr));
    end
    for (int i = 0; i < extra; i++)
      exp_q.push_back(op == 5'b11011 ? step_exp(6, instr) : ctl_t'('0));
    if (clr_at > 0)
      for (int i = clr_at; i < exp_q.size(); i++) exp_q[i] = '0;

    ir = instr; start = 1'b1; clear = 1'b1; mem_ready = (stalls == 0);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      chk($sformatf("op%b_c%0d", op, c), 64'(obs), 64'(e));
      chk($sformatf("onehot_op%b_c%0d", op, c),
          64'($countones({PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Cout,
                          Inport_out, r_out}) <= 1), 64'd1);
      start = hold_start;
      mem_ready = (c >= stalls + 2);
      clear = (c != clr_at);
    end
    start = 1'b0; clear = 1'b1; mem_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_state", 64'(obs), 64'd0);
    clear = 1'b1;
    @(negedge clock);
    chk("idle_no_start", 64'(obs), 64'd0);

    run(32'h18918000, 0, 0, 1'b0, 1);                 // ADD R1,R2,R3
    run(32'h18918000, 3, 0, 1'b0, 1);                 // fetch stall
    run(mk_ir(5'b01100, 4'd4, 4'd5, 4'd0), 0, 0, 1'b0, 1);   // ADDI
    run(mk_ir(5'b00100, 4'd6, 4'd7, 4'd8), 1, 0, 1'b0, 1);   // SUB
    run(mk_ir(5'b00101, 4'd9, 4'd10, 4'd11), 0, 0, 1'b0, 1); // AND
    run(mk_ir(5'b00110, 4'd15, 4'd0, 4'd14), 0, 0, 1'b0, 1); // OR
    run(mk_ir(5'b10000, 4'd7, 4'd0, 4'd0), 0, 0, 1'b0, 1);   // MFHI
    run(mk_ir(5'b10001, 4'd12, 4'd0, 4'd0), 0, 0, 1'b0, 1);  // MFLO
    run(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0, 1'b0, 1);   // NOP
    run(mk_ir(5'b11111, 4'd3, 4'd0, 4'd0), 0, 0, 1'b0, 1);   // undecoded
    run(mk_ir(5'b10110, 4'd2, 4'd0, 4'd0), 0, 0, 1'b0, 1);   // IN
    run(mk_ir(5'b10111, 4'd5, 4'd0, 4'd0), 0, 0, 1'b0, 1);   // OUT
    run(32'h18918000, 0, 5, 1'b0, 1);                 // clear during T4

    run(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 0, 1'b1, 3);   // HALT, start held
    start = 1'b0; clear = 1'b0;
    @(negedge clock);
    chk("halt_clear", 64'(obs), 64'd0);
    clear = 1'b1;
    @(negedge clock);
    chk("after_halt_idle", 64'(obs), 64'd0);

    run(32'h18918000, 0, 0, 1'b0, 1);                 // recovers after HALT

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/control_step_sequencer.md
Name: control_step_sequencer

Overview:
- Upstream control stage that feeds the bus source encoder.
- Steps one instruction at a time through fetch and execute.
- Each cycle it drives the one-hot bus-source strobes, meaning at most one "*out" signal is high, plus the destination, memory and ALU controls for the datapath.
- Consumes IR fields and a memory-ready handshake. Reports busy, done, illegal and halted.

Parameters:
- NREGS, 16, number of general registers; sets the width of r_out and r_in.
- OPW, 5, opcode field width, taken from ir[31:27].

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-low reset; sampled on the rising edge of clock.
- start  in  1  begin one instruction; sampled only in IDLE.
- ir  in  32  instruction register contents: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15].
- mem_ready  in  1  memory read data valid.
- PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Cout, Inport_out  out  1 each  bus source strobes.
- r_out  out  NREGS  register source strobes.
- PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read, OutPort_in  out  1 each  destination and memory controls.
- r_in  out  NREGS  register write enables.
- alu_op  out  4  ALU operation select; the value is valid in cycles where Zin=1.
- busy  out  1  high in every state except IDLE and HALT.
- done  out  1  one-cycle pulse on the final step of an instruction.
- illegal  out  1  one-cycle pulse together with done when the opcode is undecoded.
- halted  out  1  high while in HALT.

Behaviour:
- State register: IDLE, T0..T5, HALT.
- All outputs are combinational from the registered state and ir (Moore per step).
- Reset (clear=0 at an edge): state becomes IDLE in the same edge, even mid-instruction or in HALT. Every output is then 0.
- Invariant: the number of high bus source strobes across all eight strobes plus r_out is at most 1 in every cycle. In IDLE and HALT it is 0.
- IDLE: start=1 moves to T0 on the next edge; otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, Zin; alu_op=ADD. Next state T1.
- T1: Zlo_out, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0, holding these outputs every stall cycle.
  - Go to T2 on the edge where mem_ready=1.
- T2: MDRout, IRin. Next state T3. ir is valid from T3 onward.
- T3, decoded on op:
  - ADD(00011), SUB(00100), AND(00101), OR(00110), ADDI(01100): r_out[rb], Yin. Next state T4.
  - MFHI(10000): HIout, r_in[ra], done. Next state IDLE.
  - MFLO(10001): LOout, r_in[ra], done. Next state IDLE.
  - NOP(11010): done. Next state IDLE.
  - HALT(11011): done. Next state HALT.
  - Any other op: done and illegal. Next state IDLE.
- T4:
  - R-type: r_out[rc], Zin, alu_op from op.
  - ADDI: Cout, Zin, alu_op=ADD.
  - Next state T5.
- T5: Zlo_out, r_in[ra], done. Next state IDLE.
- start while busy is ignored. start in the cycle done is high is also ignored: a new instruction needs start in IDLE, so there is a one-cycle gap.
- HALT: halted=1 and all controls are 0. Exit is by reset only.
- Latency with mem_ready held high:
  - R-type/ADDI: start edge, then T0..T5, 6 cycles, done in T5.
  - MFHI/MFLO/NOP: 4 cycles.
- r_out and r_in index with 4-bit fields. When NREGS<16, out-of-range indices drive no strobe.
- alu_op encodings: ADD=0, SUB=1, AND=2, OR=3.

Optional Feature:
- Macro: SEQ_IO_EN.
- When defined:
  - IN(10110) in T3 drives Inport_out, r_in[ra], done.
  - OUT(10111) in T3 drives r_out[ra], OutPort_in, done.
- When undefined: both opcodes take the illegal path and OutPort_in is tied to 0.

Decomposition:
- Package seq_pkg holds:
  - opcode localparams;
  - the state enum (IDLE, T0..T5, HALT);
  - alu_op encodings;
  - IR field bit positions.
- Sub-module step_decoder: purely combinational, mapping state + op + ra/rb/rc to all control outputs.
- The top level keeps the state register and the transition logic.

Test Plan:
- ADD R1,R2,R3 (ir=0x18918000), mem_ready=1, start pulse:
  - exact step sequence T0..T5;
  - r_out[2]/Yin in T3, r_out[3]/Zin/alu_op=0 in T4;
  - r_in[1]/Zlo_out/done in T5, six cycles after the start edge.
- Fetch stall, mem_ready low for 3 cycles: T1 held 4 cycles with Read=MDRin=1 each cycle; IRin is asserted exactly once.
- ADDI R4,R5,imm: Cout=1 and alu_op=0 in T4; r_in[4] in T5. The one-hot source check passes every cycle.
- MFHI R7: HIout, r_in[7], done in T3; busy returns to 0 the next cycle.
- Opcode 11111: illegal and done together in T3, then IDLE. HALT: halted=1 and start is ignored until clear=0 for 1 cycle, after which all outputs are 0.
- clear deasserted-low during T4: the next cycle is IDLE, no r_in pulse occurs, and done is never asserted.
